adapter_narrow_to_wide_avalon_st: RTL and testbench

ADAPTER_NARROW_TO_WIDE_AVALON_ST -- requirements
Module: adapter_narrow_to_wide_avalon_st

---
 rtl/adapter_narrow_to_wide_avalon_st_if.sv | 38 +++
 rtl/adapter_narrow_to_wide_avalon_st.sv | 73 +++++++
 tb/tb_adapter_narrow_to_wide_avalon_st.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adapter_narrow_to_wide_avalon_st_if.sv
// adapter_narrow_to_wide_avalon_st_if: narrow sink / wide source Avalon-ST bundle.
// Framing signals exist only when ADAPTER_PACKET_EN is defined.
interface adapter_narrow_to_wide_avalon_st_if #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 2
);
   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
`ifdef ADAPTER_PACKET_EN
   localparam int EMPTY_WIDTH = (RATIO > 2) ? $clog2(RATIO) : 1;
   logic                   in_startofpacket;
   logic                   in_endofpacket;
   logic                   out_startofpacket;
   logic                   out_endofpacket;
   logic [EMPTY_WIDTH-1:0] out_empty;
`endif
   modport slave (
      input  in_valid, in_data, out_ready,
`ifdef ADAPTER_PACKET_EN
      input  in_startofpacket, in_endofpacket,
      output out_startofpacket, out_endofpacket, out_empty,
`endif
      output in_ready, out_valid, out_data
   );
   modport master (
      output in_valid, in_data, out_ready,
`ifdef ADAPTER_PACKET_EN
      output in_startofpacket, in_endofpacket,
      input  out_startofpacket, out_endofpacket, out_empty,
`endif
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/adapter_narrow_to_wide_avalon_st.sv
// adapter_narrow_to_wide_avalon_st: packs RATIO narrow beats (first beat in MSBs) into one wide word.
// Define ADAPTER_PACKET_EN for sop/eop framing with early word completion and out_empty.
module adapter_narrow_to_wide_avalon_st #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 2
) (
   input logic clock,
   input logic reset_n,
   adapter_narrow_to_wide_avalon_st_if.slave bus
);
   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int CW        = (RATIO > 2) ? $clog2(RATIO) : 1;
   logic [CW-1:0]        r_cnt;
   logic [OUT_WIDTH-1:0] r_acc;
   logic [OUT_WIDTH-1:0] r_data;
   logic                 r_valid;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_done;
   logic [OUT_WIDTH-1:0] w_word;
   assign bus.in_ready  = !r_valid || bus.out_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign w_accept      = bus.in_valid && bus.in_ready;
   // r_acc is cleared on every completion, so unwritten slots are always zero
   assign w_word        = r_acc | (OUT_WIDTH'(bus.in_data) << (IN_WIDTH * (RATIO - 1 - int'(r_cnt))));
`ifdef ADAPTER_PACKET_EN
   assign w_last        = (r_cnt == CW'(RATIO - 1)) || bus.in_endofpacket;
`else
   assign w_last        = r_cnt == CW'(RATIO - 1);
`endif
   assign w_done        = w_accept && w_last;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            r_acc <= w_last ? '0 : w_word;
         end
         if (w_done) r_data <= w_word;
         r_valid <= w_done || (r_valid && !bus.out_ready);
      end
   end
`ifdef ADAPTER_PACKET_EN
   logic          r_sop;
   logic          r_osop;
   logic          r_oeop;
   logic [CW-1:0] r_oempty;
   assign bus.out_startofpacket = r_osop;
   assign bus.out_endofpacket   = r_oeop;
   assign bus.out_empty         = r_oempty;
   // sop is only honoured on beat 0 of a word
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sop    <= 1'b0;
         r_osop   <= 1'b0;
         r_oeop   <= 1'b0;
         r_oempty <= '0;
      end else begin
         if (w_accept && r_cnt == '0) r_sop <= bus.in_startofpacket;
         if (w_done) begin
            r_osop   <= (r_cnt == '0) ? bus.in_startofpacket : r_sop;
            r_oeop   <= bus.in_endofpacket;
            r_oempty <= CW'(RATIO - 1) - r_cnt;
         end
      end
   end
`endif
endmodule

// File: tb/tb_adapter_narrow_to_wide_avalon_st.sv
// tb_adapter_narrow_to_wide_avalon_st: directed checks on a RATIO=2 and a RATIO=4 instance.
// Packet cases run when ADAPTER_PACKET_EN is defined.
module tb_adapter_narrow_to_wide_avalon_st;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   always #5 clock = ~clock;

   adapter_narrow_to_wide_avalon_st_if #(.IN_WIDTH(8), .RATIO(2)) ia ();
   adapter_narrow_to_wide_avalon_st_if #(.IN_WIDTH(8), .RATIO(4)) ib ();
   adapter_narrow_to_wide_avalon_st #(.IN_WIDTH(8), .RATIO(2)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia.slave));
   adapter_narrow_to_wide_avalon_st #(.IN_WIDTH(8), .RATIO(4)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input logic v, input logic [7:0] d, input logic r);
      ia.in_valid = v; ia.in_data = d; ia.out_ready = r;
   endtask

   task automatic drv_b(input logic v, input logic [7:0] d, input logic r, input logic s, input logic e);
      ib.in_valid = v; ib.in_data = d; ib.out_ready = r;
`ifdef ADAPTER_PACKET_EN
      ib.in_startofpacket = s; ib.in_endofpacket = e;
`else
      if (s || e) $display("note: framing ignored in this build");
`endif
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      drv_a(0, 8'h00, 1'b0);
      drv_b(0, 8'h00, 1'b0, 0, 0);
      // reset state
      step(); #1;
      chk("rst_a_valid", 32'(ia.out_valid), 32'h0);
      chk("rst_a_data", 32'(ia.out_data), 32'h0);
      chk("rst_a_ready", 32'(ia.in_ready), 32'h1);
      chk("rst_b_valid", 32'(ib.out_valid), 32'h0);
      chk("rst_b_data", ib.out_data, 32'h0);
      reset_n = 1'b1;
      // two beats back-to-back -> 0xA1B2
      step(); drv_a(1, 8'hA1, 1);
      step(); drv_a(1, 8'hB2, 1); #1;
      chk("ab_valid_early", 32'(ia.out_valid), 32'h0);
      chk("ab_ready", 32'(ia.in_ready), 32'h1);
      step(); drv_a(0, 8'h00, 1); #1;
      chk("ab_valid", 32'(ia.out_valid), 32'h1);
      chk("ab_data", 32'(ia.out_data), 32'hA1B2);
      step(); #1;
      chk("ab_drop", 32'(ia.out_valid), 32'h0);
      // backpressure holds 0x1122
      step(); drv_a(1, 8'h11, 0);
      step(); drv_a(1, 8'h22, 0);
      step(); drv_a(1, 8'h33, 0); #1;
      chk("bp_valid", 32'(ia.out_valid), 32'h1);
      chk("bp_ready", 32'(ia.in_ready), 32'h0);
      chk("bp_data", 32'(ia.out_data), 32'h1122);
      for (int i = 0; i < 10; i++) begin
         step(); #1;
         chk("bp_hold_data", 32'(ia.out_data), 32'h1122);
         chk("bp_hold_ready", 32'(ia.in_ready), 32'h0);
      end
      step(); drv_a(1, 8'h33, 1); #1;
      chk("bp_release_ready", 32'(ia.in_ready), 32'h1);
      step(); drv_a(1, 8'h44, 1); #1;
      chk("bp_after_drop", 32'(ia.out_valid), 32'h0);
      step(); drv_a(0, 8'h00, 1); #1;
      chk("bp_next_valid", 32'(ia.out_valid), 32'h1);
      chk("bp_next_data", 32'(ia.out_data), 32'h3344);
      // reset mid-word discards partial beat 0xFF
      step(); drv_a(1, 8'hFF, 1);
      step(); drv_a(0, 8'h00, 1); reset_n = 1'b0; #1;
      chk("mid_rst_valid", 32'(ia.out_valid), 32'h0);
      chk("mid_rst_data", 32'(ia.out_data), 32'h0);
      chk("mid_rst_ready", 32'(ia.in_ready), 32'h1);
      step(); reset_n = 1'b1;
      step(); drv_a(1, 8'h33, 1);
      step(); drv_a(1, 8'h44, 1);
      step(); drv_a(0, 8'h00, 1); #1;
      chk("post_rst_valid", 32'(ia.out_valid), 32'h1);
      chk("post_rst_data", 32'(ia.out_data), 32'h3344);
      // RATIO=4 streaming of 0x01..0x08
      for (int i = 0; i < 10; i++) begin
         step();
         drv_b(i < 8, 8'(i + 1), 1, 0, 0); #1;
         chk("str_ready", 32'(ib.in_ready), 32'h1);
         chk("str_valid", 32'(ib.out_valid), (i == 4 || i == 8) ? 32'h1 : 32'h0);
         if (i == 4) chk("str_word0", ib.out_data, 32'h01020304);
         if (i == 8) chk("str_word1", ib.out_data, 32'h05060708);
      end
`ifdef ADAPTER_PACKET_EN
      // short packet: 3 beats, empty=1
      step(); drv_b(1, 8'h10, 1, 1, 0);
      step(); drv_b(1, 8'h20, 1, 0, 0);
      step(); drv_b(1, 8'h30, 1, 0, 1);
      step(); drv_b(1, 8'h55, 1, 1, 1); #1;
      chk("pk_valid", 32'(ib.out_valid), 32'h1);
      chk("pk_data", ib.out_data, 32'h10203000);
      chk("pk_sop", 32'(ib.out_startofpacket), 32'h1);
      chk("pk_eop", 32'(ib.out_endofpacket), 32'h1);
      chk("pk_empty", 32'(ib.out_empty), 32'h1);
      // single-beat packets reload the output with no bubble
      step(); drv_b(1, 8'h66, 1, 1, 1); #1;
      chk("one_valid", 32'(ib.out_valid), 32'h1);
      chk("one_data", ib.out_data, 32'h55000000);
      chk("one_empty", 32'(ib.out_empty), 32'h3);
      chk("one_sop", 32'(ib.out_startofpacket), 32'h1);
      step(); drv_b(0, 8'h00, 1, 0, 0); #1;
      chk("two_valid", 32'(ib.out_valid), 32'h1);
      chk("two_data", ib.out_data, 32'h66000000);
      // full packet, sop on beat 2 ignored
      step(); drv_b(1, 8'hAA, 1, 1, 0);
      step(); drv_b(1, 8'hBB, 1, 0, 0);
      step(); drv_b(1, 8'hCC, 1, 1, 0);
      step(); drv_b(1, 8'hDD, 1, 0, 1);
      step(); drv_b(0, 8'h00, 1, 0, 0); #1;
      chk("full_data", ib.out_data, 32'hAABBCCDD);
      chk("full_empty", 32'(ib.out_empty), 32'h0);
      chk("full_sop", 32'(ib.out_startofpacket), 32'h1);
      chk("full_eop", 32'(ib.out_endofpacket), 32'h1);
`endif
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
